// File: rtl/mealy_accum_mc_if.sv
// mealy_accum_mc_if
//   Sample-in / result-out bundle for mealy_accum_mc.
//   slave  : the accumulator's view (samples and out_ready in, results out)
//   master : the source/sink view (mirror of slave)
//   Input side : in_valid, in_ready, in_chan, in_data, in_clear
//   Flush      : flush_req, flush_busy
//   Output side: out_valid, out_ready, out_chan, out_data, out_flush, out_sat
interface mealy_accum_mc_if #(
    parameter int DATA_W = 9,
    parameter int ACC_W  = 12,
    parameter int NCH    = 4,
    parameter int CH_W   = $clog2(NCH)
);
    logic                     in_valid;
    logic                     in_ready;
    logic [CH_W-1:0]          in_chan;
    logic signed [DATA_W-1:0] in_data;
    logic                     in_clear;
    logic                     flush_req;
    logic                     flush_busy;
    logic                     out_valid;
    logic                     out_ready;
    logic [CH_W-1:0]          out_chan;
    logic signed [ACC_W-1:0]  out_data;
    logic                     out_flush;
    logic                     out_sat;

    modport slave (
        input  in_valid, in_chan, in_data, in_clear, flush_req, out_ready,
        output in_ready, flush_busy, out_valid, out_chan, out_data, out_flush, out_sat
    );

    modport master (
        output in_valid, in_chan, in_data, in_clear, flush_req, out_ready,
        input  in_ready, flush_busy, out_valid, out_chan, out_data, out_flush, out_sat
    );
endinterface

// File: rtl/mealy_accum_mc.sv
// mealy_accum_mc
//   Multi-channel Mealy accumulator. Each accepted sample emits its channel's
//   pre-update sum; the channel then holds sum + sample (or the sample alone
//   when in_clear). A flush request dumps every channel in order and zeroes it.
//   Ports:
//     system1000      : clock, rising edge
//     system1000_rstn : asynchronous active-low reset
//     bus             : mealy_accum_mc_if.slave (handshakes, data, flush)
//   Optional build macro MEALY_ACCUM_MC_SAT_EN: sums clamp to the ACC_W signed
//   range and out_sat flags the clamped beat; otherwise sums wrap and out_sat=0.
module mealy_accum_mc #(
    parameter int DATA_W = 9,
    parameter int ACC_W  = 12,
    parameter int NCH    = 4,
    parameter int CH_W   = $clog2(NCH)
) (
    input  logic system1000,
    input  logic system1000_rstn,
    mealy_accum_mc_if.slave bus
);
    typedef enum logic {IDLE, FLUSH} state_t;

    localparam logic [CH_W:0]   NCH_L  = (CH_W+1)'(NCH);
    localparam logic [CH_W-1:0] K_LAST = CH_W'(NCH - 1);

    state_t                  state_q, state_d;
    logic                    flush_pend_q, flush_pend_d;
    logic [CH_W-1:0]         k_q, k_d;
    logic signed [ACC_W-1:0] acc_q [NCH];
    logic signed [ACC_W-1:0] acc_d [NCH];
    logic                    out_valid_q, out_valid_d;
    logic [CH_W-1:0]         out_chan_q, out_chan_d;
    logic signed [ACC_W-1:0] out_data_q, out_data_d;
    logic                    out_flush_q, out_flush_d;

    logic                    out_free, in_fire, legal;
    logic signed [ACC_W-1:0] acc_sel, upd;
    logic                    ovf;

    // Output register may take a new beat when empty or being drained now.
    assign out_free    = ~out_valid_q | bus.out_ready;
    assign bus.in_ready = (state_q == IDLE) & ~flush_pend_q & out_free;
    assign in_fire     = bus.in_valid & bus.in_ready;
    assign legal       = {1'b0, bus.in_chan} < NCH_L;
    assign acc_sel     = acc_q[bus.in_chan];

`ifdef MEALY_ACCUM_MC_SAT_EN
    logic signed [ACC_W:0] sum;
    logic                  out_sat_q, out_sat_d;

    // One extra bit catches overflow: top two bits disagree -> clamp by sign.
    always_comb begin
        sum = (ACC_W+1)'(acc_sel) + (ACC_W+1)'(bus.in_data);
        ovf = 1'b0;
        upd = sum[ACC_W-1:0];
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            ovf = 1'b1;
            upd = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
    assign bus.out_sat = out_sat_q;
`else
    assign upd         = acc_sel + ACC_W'(bus.in_data);
    assign ovf         = 1'b0;
    assign bus.out_sat = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        flush_pend_d = flush_pend_q;
        k_d          = k_q;
        acc_d        = acc_q;
        out_valid_d  = out_valid_q & ~bus.out_ready;
        out_chan_d   = out_chan_q;
        out_data_d   = out_data_q;
        out_flush_d  = out_flush_q;
`ifdef MEALY_ACCUM_MC_SAT_EN
        out_sat_d    = out_sat_q;
`endif
        case (state_q)
            IDLE: begin
                // Illegal channels are consumed with no beat and no state change.
                if (in_fire && legal) begin
                    out_valid_d = 1'b1;
                    out_chan_d  = bus.in_chan;
                    out_data_d  = acc_sel;
                    out_flush_d = 1'b0;
`ifdef MEALY_ACCUM_MC_SAT_EN
                    out_sat_d   = ~bus.in_clear & ovf;
`endif
                    acc_d[bus.in_chan] = bus.in_clear ? ACC_W'(bus.in_data) : upd;
                end
                // in_ready already excludes flush_pend, so a flush never races a sample.
                if (flush_pend_q && out_free) begin
                    state_d      = FLUSH;
                    flush_pend_d = 1'b0;
                end else if (bus.flush_req) begin
                    flush_pend_d = 1'b1;
                end
            end
            FLUSH: begin
                if (out_free) begin
                    out_valid_d = 1'b1;
                    out_chan_d  = k_q;
                    out_data_d  = acc_q[k_q];
                    out_flush_d = 1'b1;
`ifdef MEALY_ACCUM_MC_SAT_EN
                    out_sat_d   = 1'b0;
`endif
                    acc_d[k_q]  = '0;
                    if (k_q == K_LAST) begin
                        k_d     = '0;
                        state_d = IDLE;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state_q      <= IDLE;
            flush_pend_q <= 1'b0;
            k_q          <= '0;
            for (int i = 0; i < NCH; i++) acc_q[i] <= '0;
            out_valid_q  <= 1'b0;
            out_chan_q   <= '0;
            out_data_q   <= '0;
            out_flush_q  <= 1'b0;
`ifdef MEALY_ACCUM_MC_SAT_EN
            out_sat_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
            k_q          <= k_d;
            acc_q        <= acc_d;
            out_valid_q  <= out_valid_d;
            out_chan_q   <= out_chan_d;
            out_data_q   <= out_data_d;
            out_flush_q  <= out_flush_d;
`ifdef MEALY_ACCUM_MC_SAT_EN
            out_sat_q    <= out_sat_d;
`endif
        end
    end

    assign bus.flush_busy = (state_q == FLUSH) | flush_pend_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_chan   = out_chan_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_flush  = out_flush_q;
endmodule
